// File: rtl/board_display_driver_if.sv
// Board-to-LED-chain bus: memory-mapped board words in, 74HC595 chain controls out.
interface board_display_driver_if;
  logic [31:0] playerBoard;
  logic [31:0] cpuBoard;
  logic [31:0] kingBoard;
  logic        force_refresh;
  logic        sr_data;
  logic        sr_clk;
  logic        sr_latch;
  logic        sr_oe_n;
  logic        busy;
  logic        frame_done;

  modport master (
    output playerBoard, cpuBoard, kingBoard, force_refresh,
    input  sr_data, sr_clk, sr_latch, sr_oe_n, busy, frame_done
  );

  modport slave (
    input  playerBoard, cpuBoard, kingBoard, force_refresh,
    output sr_data, sr_clk, sr_latch, sr_oe_n, busy, frame_done
  );
endinterface

// File: rtl/board_display_driver.sv
// Serialises the player/cpu/king board words onto a 74HC595-style LED chain.
// A frame is sent only on board change, forced refresh, or king blink toggle.
//
// state | meaning
// IDLE  | chain static; watch for pending, force_refresh or board change
// LOAD  | snapshot boards + blink phase, build 64-bit frame word
// SHIFT | clock 64 bits out MSB first, CLK_DIV cycles low then high per bit
// LATCH | pulse storage latch for CLK_DIV cycles, then enable outputs
module board_display_driver #(
  parameter int CLK_DIV   = 4,
  parameter int BLINK_DIV = 10000000
) (
  input  logic                         clk,
  input  logic                         reset,
  board_display_driver_if.slave        bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;
  logic             phase_hi;
  logic [5:0]       bit_cnt;
  logic [63:0]      frame_q;
  logic [63:0]      frame_word;
  logic [31:0]      snap_player, snap_cpu, snap_king;
  logic             board_changed;
  logic             pending;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             blink_tog;
  logic             oe_n_q;
  logic             done_q;
  logic             sr_data_c, sr_clk_c, sr_latch_c, busy_c;

  assign div_tc        = (div_cnt == '0);
  assign blink_tog     = (blink_cnt == BLK_LAST);
  assign board_changed = ({bus.playerBoard, bus.cpuBoard, bus.kingBoard} !=
                          {snap_player, snap_cpu, snap_king});

  // Frame word: two bits per square, king squares blanked during the off phase.
  always_comb begin
    frame_word = '0;
    for (int i = 0; i < 32; i++) begin
      frame_word[2*i+1] = bus.cpuBoard[i]    & ~(bus.kingBoard[i] & blink_phase);
      frame_word[2*i]   = bus.playerBoard[i] & ~(bus.kingBoard[i] & blink_phase);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and chain control decode.
  always_comb begin
    state_nxt  = state;
    sr_data_c  = 1'b0;
    sr_clk_c   = 1'b0;
    sr_latch_c = 1'b0;
    busy_c     = 1'b1;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (pending || bus.force_refresh || board_changed) state_nxt = LOAD;
      end
      LOAD: state_nxt = SHIFT;
      SHIFT: begin
        sr_data_c = frame_q[63];
        sr_clk_c  = phase_hi;
        if (div_tc && phase_hi && (bit_cnt == 6'd0)) state_nxt = LATCH;
      end
      LATCH: begin
        sr_latch_c = 1'b1;
        if (div_tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath: half-bit timer, bit counter, frame shifter, output enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= DIV_LAST;
      phase_hi    <= 1'b0;
      bit_cnt     <= 6'd63;
      frame_q     <= '0;
      snap_player <= '0;
      snap_cpu    <= '0;
      snap_king   <= '0;
      oe_n_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        LOAD: begin
          snap_player <= bus.playerBoard;
          snap_cpu    <= bus.cpuBoard;
          snap_king   <= bus.kingBoard;
          frame_q     <= frame_word;
          bit_cnt     <= 6'd63;
          div_cnt     <= DIV_LAST;
          phase_hi    <= 1'b0;
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= DIV_LAST;
            if (phase_hi) begin
              phase_hi <= 1'b0;
              if (bit_cnt != 6'd0) begin
                bit_cnt <= bit_cnt - 6'd1;
                frame_q <= {frame_q[62:0], 1'b0};
              end
            end else begin
              phase_hi <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        LATCH: begin
          if (div_tc) begin
            done_q <= 1'b1;
            oe_n_q <= 1'b0;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Blink timer and refresh-request latch; set requests win over the LOAD clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pending     <= 1'b1;
    end else begin
      if (blink_tog) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if ((blink_tog && (bus.kingBoard != 32'd0)) ||
          (bus.force_refresh && (state != IDLE)))
        pending <= 1'b1;
      else if (state == LOAD)
        pending <= 1'b0;
    end
  end

  assign bus.sr_data    = sr_data_c;
  assign bus.sr_clk     = sr_clk_c;
  assign bus.sr_latch   = sr_latch_c;
  assign bus.busy       = busy_c;
  assign bus.sr_oe_n    = oe_n_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_board_display_driver.sv
// Directed bench for board_display_driver with a behavioural 74HC595 chain model.
module tb_board_display_driver;
  localparam int CLK_DIV   = 2;
  localparam int BLINK_DIV = 50;
  localparam int FRAME_LEN = 1 + 128*CLK_DIV + CLK_DIV;

  logic clk;
  logic reset;
  board_display_driver_if bus();

  board_display_driver #(.CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Chain model: shift on sr_clk rise, capture on sr_latch rise.
  logic [63:0] chain   = '0;
  logic [63:0] cap_word = '0;
  int          latches = 0;
  always @(posedge bus.sr_clk) chain = {chain[62:0], bus.sr_data};
  always @(posedge bus.sr_latch) begin
    cap_word = chain;
    latches++;
  end

  // Cycle monitor, sampled 1 ns after each active edge.
  int   cyc = 0, loads = 0, dones = 0, load_cyc = 0, done_cyc = 0;
  int   clk_hi = 0, latch_hi = 0;
  logic busy_prev = 1'b0;
  logic load_phase = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      cyc       = 0;
      busy_prev = 1'b0;
    end else begin
      cyc++;
      if (bus.busy && !busy_prev) begin
        loads++;
        load_cyc   = cyc;
        load_phase = ((cyc / BLINK_DIV) % 2) == 1;
      end
      if (bus.frame_done) begin
        dones++;
        done_cyc = cyc;
      end
      busy_prev = bus.busy;
    end
    if (bus.sr_clk)   clk_hi++;
    if (bus.sr_latch) latch_hi++;
  end

  task automatic wait_loads(input int target, input int budget);
    int n = 0;
    while (loads < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (dones < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_force();
    @(negedge clk);
    bus.force_refresh = 1'b1;
    @(negedge clk);
    bus.force_refresh = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_sr_data"},    64'(bus.sr_data),    64'd0);
    chk({pfx, "_sr_clk"},     64'(bus.sr_clk),     64'd0);
    chk({pfx, "_sr_latch"},   64'(bus.sr_latch),   64'd0);
    chk({pfx, "_sr_oe_n"},    64'(bus.sr_oe_n),    64'd1);
    chk({pfx, "_busy"},       64'(bus.busy),       64'd0);
    chk({pfx, "_frame_done"}, 64'(bus.frame_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, d, hi0, lat0;
    logic [63:0] exp_w;
    logic        seen0, seen1;

    reset             = 1'b1;
    bus.playerBoard   = '0;
    bus.cpuBoard      = '0;
    bus.kingBoard     = '0;
    bus.force_refresh = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // Frame forced by reset release, all boards empty.
    reset = 1'b0;
    wait_dones(1, 1000);
    chk("t1_done",       64'(dones), 64'd1);
    chk("t1_first_load", 64'(load_cyc), 64'd1);
    chk("t1_len",        64'(done_cyc - load_cyc), 64'(FRAME_LEN));
    chk("t1_word",       cap_word, 64'd0);
    chk("t1_clk_hi",     64'(clk_hi), 64'd128);
    chk("t1_latch_hi",   64'(latch_hi), 64'd2);
    chk("t1_latches",    64'(latches), 64'd1);
    chk("t1_busy_done",  64'(bus.busy), 64'd0);
    chk("t1_oe_n",       64'(bus.sr_oe_n), 64'd0);

    // Corner squares: player square 0, cpu square 31.
    base = dones;
    @(negedge clk);
    bus.playerBoard = 32'h0000_0001;
    bus.cpuBoard    = 32'h8000_0000;
    wait_dones(base + 1, 1000);
    chk("t2_word", cap_word, 64'h8000_0000_0000_0001);
    repeat (600) @(negedge clk);
    chk("t2_one_frame", 64'(dones), 64'(base + 1));
    chk("t2_idle",      64'(bus.busy), 64'd0);

    // cpu square 10 appears mid-frame (around bit 40).
    base = dones;
    d    = loads;
    pulse_force();
    wait_loads(d + 1, 20);
    repeat (92) @(negedge clk);
    bus.cpuBoard = 32'h8000_0400;
    wait_dones(base + 1, 1000);
    chk("t3_old_word", cap_word, 64'h8000_0000_0000_0001);
    d = done_cyc;
    wait_dones(base + 2, 1000);
    chk("t3_back2back", 64'(load_cyc), 64'(d + 1));
    chk("t3_new_word",  cap_word, 64'h8000_0000_0020_0001);
    chk("t3_bit21",     64'(cap_word[21]), 64'd1);

    // force_refresh once in IDLE and once while busy.
    repeat (20) @(negedge clk);
    base = dones;
    d    = loads;
    pulse_force();
    wait_loads(d + 1, 20);
    repeat (20) @(negedge clk);
    pulse_force();
    wait_dones(base + 1, 1000);
    chk("t4_word1", cap_word, 64'h8000_0000_0020_0001);
    d = done_cyc;
    wait_dones(base + 2, 1000);
    chk("t4_back2back", 64'(load_cyc), 64'(d + 1));
    chk("t4_word2", cap_word, 64'h8000_0000_0020_0001);
    repeat (600) @(negedge clk);
    chk("t4_two_frames", 64'(dones), 64'(base + 2));

    // King on square 0 blinks the player LED.
    base  = dones;
    seen0 = 1'b0;
    seen1 = 1'b0;
    @(negedge clk);
    bus.kingBoard = 32'h0000_0001;
    for (int f = 0; f < 4; f++) begin
      wait_dones(base + f + 1, 1000);
      exp_w = load_phase ? 64'h8000_0000_0020_0000 : 64'h8000_0000_0020_0001;
      chk("t5_blink_word", cap_word, exp_w);
      if (load_phase) seen1 = 1'b1;
      else            seen0 = 1'b1;
    end
    chk("t5_both_phases", 64'({seen0, seen1}), 64'd3);
    @(negedge clk);
    bus.kingBoard = 32'h0000_0000;
    repeat (1100) @(negedge clk);
    base = dones;
    repeat (500) @(negedge clk);
    chk("t5_no_blink_frames", 64'(dones), 64'(base));
    chk("t5_word_lit", cap_word, 64'h8000_0000_0020_0001);

    // Reset around bit 30 aborts; a full frame follows release.
    base = dones;
    d    = loads;
    pulse_force();
    wait_loads(d + 1, 20);
    repeat (132) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("t6_rst");
    @(negedge clk);
    reset = 1'b0;
    hi0  = clk_hi;
    lat0 = latches;
    wait_dones(base + 1, 1000);
    chk("t6_done",    64'(dones), 64'(base + 1));
    chk("t6_word",    cap_word, 64'h8000_0000_0020_0001);
    chk("t6_clk_hi",  64'(clk_hi - hi0), 64'd128);
    chk("t6_latches", 64'(latches - lat0), 64'd1);
    chk("t6_oe_n",    64'(bus.sr_oe_n), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
